// File: rtl/apb_i2c_csr_if.sv
// apb_i2c_csr_if: APB slave bus bundle for the I2C CSR block
interface apb_i2c_csr_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_i2c_csr.sv
// apb_i2c_csr: APB register block with TX/RX FIFOs, sticky status and PSLVERR for the I2C byte engine
module apb_i2c_csr #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_i2c_csr_if.slave       apb,
  output logic [7:0]         i2c_addr,
  output logic [7:0]         i2c_cnt,
  output logic               i2c_start,
  output logic [7:0]         tx_data,
  output logic               tx_empty,
  input  logic               tx_rd,
  input  logic [7:0]         rx_data,
  output logic               rx_full,
  input  logic               rx_wr,
  input  logic               i2c_busy,
  input  logic               i2c_done,
  input  logic               i2c_nack,
  output logic               irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [TAW:0]   tx_lvl;
  logic [RAW:0]   rx_lvl;
  logic           irq_en, done, nack;
  logic [2:0]     sel;
  logic           acc, wr, rd, err, tx_full, rx_empty;
  logic           tx_push, tx_pop, rx_push, rx_pop, ctrl_we, cnt_we, go, clr_done, clr_nack;
  logic [31:0]    status;
  logic           unused;
  assign unused = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:10]};
  always_comb begin
    sel      = apb.PADDR[4:2];
    acc      = apb.PSEL & apb.PENABLE;
    wr       = acc & apb.PWRITE;
    rd       = acc & ~apb.PWRITE;
    tx_full  = tx_lvl == (TAW+1)'(TX_DEPTH);
    tx_empty = tx_lvl == '0;
    rx_full  = rx_lvl == (RAW+1)'(RX_DEPTH);
    rx_empty = rx_lvl == '0;
    // a rejected access must leave every piece of state untouched
    err      = acc & ((sel > 3'd4) |
                      (sel == 3'd1 & (~apb.PWRITE | tx_full)) |
                      (sel == 3'd2 & (apb.PWRITE | rx_empty)) |
                      (sel == 3'd0 & apb.PWRITE & apb.PWDATA[9] & i2c_busy));
    ctrl_we  = wr & ~err & sel == 3'd0;
    cnt_we   = wr & sel == 3'd3;
    go       = ctrl_we & apb.PWDATA[9];
    tx_push  = wr & ~err & sel == 3'd1;
    tx_pop   = tx_rd & ~tx_empty;
    rx_push  = rx_wr & ~rx_full;
    rx_pop   = rd & ~err & sel == 3'd2;
    clr_done = go | (wr & sel == 3'd4 & apb.PWDATA[0]);
    clr_nack = go | (wr & sel == 3'd4 & apb.PWDATA[1]);
    status   = {8'h0, 8'(rx_lvl), 8'(tx_lvl), 1'b0, rx_empty, rx_full, tx_empty, tx_full, i2c_busy, nack, done};
    apb.PRDATA = (~rd | err)     ? 32'h0 :
                 (sel == 3'd0)   ? {22'h0, irq_en, i2c_addr} :
                 (sel == 3'd2)   ? {24'h0, rx_mem[rx_rp]} :
                 (sel == 3'd3)   ? {24'h0, i2c_cnt} :
                 (sel == 3'd4)   ? status : 32'h0;
  end
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;
  assign tx_data     = tx_mem[tx_rp];
  assign irq         = irq_en & (done | nack);
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= apb.PWDATA[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      i2c_addr  <= '0;
      irq_en    <= 1'b0;
      i2c_cnt   <= '0;
      i2c_start <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_lvl    <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_lvl    <= '0;
    end else begin
      if (ctrl_we) {irq_en, i2c_addr} <= apb.PWDATA[8:0];
      if (cnt_we) i2c_cnt <= apb.PWDATA[7:0];
      i2c_start <= go;
      // a new engine event wins over a clear in the same cycle
      done      <= i2c_done | (done & ~clr_done);
      nack      <= i2c_nack | (nack & ~clr_nack);
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop) tx_rp <= tx_rp + TAW'(1);
      tx_lvl    <= tx_lvl + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop) rx_rp <= rx_rp + RAW'(1);
      rx_lvl    <= rx_lvl + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end
  end
endmodule

// File: tb/tb_apb_i2c_csr.sv
// tb_apb_i2c_csr: directed plus random APB/engine traffic against a queue-based reference model
module tb_apb_i2c_csr;
  localparam int TXD = 8;
  localparam int RXD = 8;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;
  apb_i2c_csr_if bus();
  logic [7:0] i2c_addr, i2c_cnt, tx_data, rx_data;
  logic       i2c_start, tx_empty, tx_rd, rx_full, rx_wr, i2c_busy, i2c_done, i2c_nack, irq;
  apb_i2c_csr #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus),
    .i2c_addr(i2c_addr), .i2c_cnt(i2c_cnt), .i2c_start(i2c_start),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd(tx_rd),
    .rx_data(rx_data), .rx_full(rx_full), .rx_wr(rx_wr),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .irq(irq)
  );
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic [7:0]  m_addr = 8'h0, m_cnt = 8'h0;
  logic        m_irqen = 1'b0, m_start = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [31:0] r;
  logic        e;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_err();
    logic [2:0] a;
    a = bus.PADDR[4:2];
    if (!(bus.PSEL && bus.PENABLE)) return 1'b0;
    if (a == 3'd0) return bus.PWRITE && bus.PWDATA[9] && i2c_busy;
    if (a == 3'd1) return !bus.PWRITE || tx_q.size() == TXD;
    if (a == 3'd2) return bus.PWRITE || rx_q.size() == 0;
    return a > 3'd4;
  endfunction
  function automatic logic [31:0] exp_status();
    return {8'h0, 8'(rx_q.size()), 8'(tx_q.size()), 1'b0, rx_q.size() == 0, rx_q.size() == RXD,
            tx_q.size() == 0, tx_q.size() == TXD, i2c_busy, m_nack, m_done};
  endfunction
  function automatic logic [31:0] exp_rdata();
    case (bus.PADDR[4:2])
      3'd0: return {22'h0, m_irqen, m_addr};
      3'd2: return rx_q.size() > 0 ? {24'h0, rx_q[0]} : 32'h0;
      3'd3: return {24'h0, m_cnt};
      3'd4: return exp_status();
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_step();
    logic [2:0] a;
    logic ok, st, w1, txe, rxf;
    if (PRESET) begin
      tx_q.delete();
      rx_q.delete();
      {m_addr, m_cnt, m_irqen, m_start, m_done, m_nack} = '0;
      return;
    end
    a   = bus.PADDR[4:2];
    ok  = bus.PSEL && bus.PENABLE && !exp_err();
    st  = ok && bus.PWRITE && a == 3'd0 && bus.PWDATA[9];
    w1  = ok && bus.PWRITE && a == 3'd4;
    txe = tx_q.size() == 0;
    rxf = rx_q.size() == RXD;
    if (ok && bus.PWRITE && a == 3'd0) {m_irqen, m_addr} = bus.PWDATA[8:0];
    if (ok && bus.PWRITE && a == 3'd3) m_cnt = bus.PWDATA[7:0];
    if (tx_rd && !txe) void'(tx_q.pop_front());
    if (ok && bus.PWRITE && a == 3'd1) tx_q.push_back(bus.PWDATA[7:0]);
    if (ok && !bus.PWRITE && a == 3'd2) void'(rx_q.pop_front());
    if (rx_wr && !rxf) rx_q.push_back(rx_data);
    m_done  = i2c_done || (m_done && !(st || (w1 && bus.PWDATA[0])));
    m_nack  = i2c_nack || (m_nack && !(st || (w1 && bus.PWDATA[1])));
    m_start = st;
  endtask
  task automatic check_outputs();
    check("tx_empty", tx_empty, tx_q.size() == 0);
    check("rx_full", rx_full, rx_q.size() == RXD);
    check("i2c_start", i2c_start, m_start);
    check("i2c_addr", i2c_addr, m_addr);
    check("i2c_cnt", i2c_cnt, m_cnt);
    check("irq", irq, m_irqen && (m_done || m_nack));
    check("pready", bus.PREADY, 1'b1);
    if (tx_q.size() > 0) check("tx_data", tx_data, tx_q[0]);
  endtask
  task automatic cyc();
    model_step();
    @(posedge PCLK);
    @(negedge PCLK);
    check_outputs();
  endtask
  task automatic apb(input logic w, input logic [2:0] a, input logic [31:0] d, input logic pop,
                     input logic dn, output logic [31:0] rd_val, output logic er);
    bus.PADDR = $urandom;
    bus.PADDR[4:2] = a;
    bus.PWRITE = w;
    bus.PWDATA = d;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    cyc();
    bus.PENABLE = 1'b1;
    tx_rd = pop;
    i2c_done = dn;
    #1;
    check("pslverr", bus.PSLVERR, exp_err());
    if (!w) check("prdata", bus.PRDATA, exp_rdata());
    rd_val = bus.PRDATA;
    er = bus.PSLVERR;
    cyc();
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    tx_rd = 1'b0;
    i2c_done = 1'b0;
  endtask
  task automatic eng(input logic rdp, input logic wrp, input logic [7:0] d, input logic dn, input logic nk);
    tx_rd = rdp;
    rx_wr = wrp;
    rx_data = d;
    i2c_done = dn;
    i2c_nack = nk;
    cyc();
    {tx_rd, rx_wr, i2c_done, i2c_nack} = '0;
  endtask
  initial begin
    {tx_rd, rx_wr, i2c_busy, i2c_done, i2c_nack} = '0;
    rx_data = 8'h0;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
    repeat (3) cyc();
    PRESET = 1'b0;
    cyc();
    apb(0, 3'd4, 0, 0, 0, r, e); check("rst_status", r, 32'h50);
    apb(0, 3'd0, 0, 0, 0, r, e); check("rst_ctrl", r, 32'h0);
    apb(0, 3'd3, 0, 0, 0, r, e); check("rst_count", r, 32'h0);
    for (int i = 0; i < 8; i++) apb(1, 3'd1, 32'h11 + i, 0, 0, r, e);
    apb(0, 3'd4, 0, 0, 0, r, e);
    check("tx_full_bit", r[3], 1);
    check("tx_level_full", r[15:8], 8);
    apb(1, 3'd1, 32'h99, 0, 0, r, e); check("tx_ovf_err", e, 1);
    apb(0, 3'd4, 0, 0, 0, r, e); check("tx_level_ovf", r[15:8], 8);
    for (int i = 0; i < 8; i++) begin
      check("tx_seq", tx_data, 32'h11 + i);
      eng(1, 0, 0, 0, 0);
    end
    check("tx_drained", tx_empty, 1);
    for (int i = 0; i < 8; i++) eng(0, 1, 8'h30 + 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      apb(0, 3'd2, 0, 0, 0, r, e); check("rx_seq_a", r, 32'h30 + i);
    end
    for (int i = 8; i < 12; i++) eng(0, 1, 8'h30 + 8'(i), 0, 0);
    for (int i = 4; i < 12; i++) begin
      apb(0, 3'd2, 0, 0, 0, r, e); check("rx_seq_b", r, 32'h30 + i);
    end
    apb(0, 3'd2, 0, 0, 0, r, e);
    check("rx_empty_err", e, 1);
    check("rx_empty_data", r, 0);
    apb(1, 3'd0, 32'h2A5, 0, 0, r, e);
    check("start_addr", i2c_addr, 8'hA5);
    check("start_pulse", i2c_start, 1);
    cyc();
    check("start_once", i2c_start, 0);
    i2c_busy = 1'b1;
    apb(1, 3'd0, 32'h3C1, 0, 0, r, e);
    check("busy_err", e, 1);
    check("busy_nostart", i2c_start, 0);
    apb(0, 3'd0, 0, 0, 0, r, e); check("busy_ctrl_kept", r, 32'hA5);
    i2c_busy = 1'b0;
    apb(1, 3'd0, 32'h1A5, 0, 0, r, e);
    eng(0, 0, 0, 1, 0);
    check("irq_set", irq, 1);
    apb(1, 3'd4, 32'h1, 0, 1, r, e);
    apb(0, 3'd4, 0, 0, 0, r, e); check("w1c_race", r[0], 1);
    apb(1, 3'd4, 32'h1, 0, 0, r, e);
    check("irq_clr", irq, 0);
    for (int i = 0; i < 3; i++) apb(1, 3'd1, 32'hA1 + i, 0, 0, r, e);
    apb(1, 3'd1, 32'hA4, 1, 0, r, e);
    apb(0, 3'd4, 0, 0, 0, r, e); check("simul_level", r[15:8], 3);
    check("simul_head", tx_data, 8'hA2);
    PRESET = 1'b1;
    cyc();
    PRESET = 1'b0;
    apb(0, 3'd4, 0, 0, 0, r, e); check("mid_reset_status", r, 32'h50);
    repeat (400) begin
      int op;
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 7) == 0) i2c_busy = ~i2c_busy;
      if (op < 12) begin
        logic [31:0] d;
        d = $urandom;
        d[9] = $urandom_range(0, 3) == 0;
        apb(1'($urandom), 3'($urandom_range(0, 7)), d, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, r, e);
      end else if (op < 19) begin
        eng(1'($urandom), $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0);
      end else begin
        PRESET = 1'b1;
        cyc();
        PRESET = 1'b0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
